// File: rtl/multi_spi_pkg.sv
// Shared encodings and width helpers for the multi-channel SPI master.
package multi_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  // A single-channel build still needs a one-bit channel field.
  function automatic int chan_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int len_width(input int max_width);
    return $clog2(max_width + 1);
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter that emits a one-cycle tick every (divisor+1) cycles.
// The divisor is captured on load so later changes do not affect a running transfer.
module spi_half_tick #(
  parameter int DIVISOR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [DIVISOR_WIDTH-1:0] load_value,
  output logic                     tick
);

  logic [DIVISOR_WIDTH-1:0] div_q, div_d;
  logic [DIVISOR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = load_value;
      cnt_d = load_value;
    end else if (cnt_q == '0) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - DIVISOR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/multi_spi_master.sv
// SPI master serving CHANNEL_COUNT mode-0 buses from one command port.
// Define MULTI_SPI_READBACK_EN to build the SDO synchronisers and capture register.
module multi_spi_master
  import multi_spi_pkg::*;
#(
  parameter int                       CHANNEL_COUNT = 2,
  parameter int                       MAX_WIDTH     = 32,
  parameter int                       DIVISOR_WIDTH = 8,
  parameter logic [CHANNEL_COUNT-1:0] LE_MASK       = '0,
  localparam int                      CW            = chan_width(CHANNEL_COUNT),
  localparam int                      LW            = len_width(MAX_WIDTH),
  localparam int                      EW            = LW + 1
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  // Command/response handshake: a command transfers on the cycle where
  // cmdValid && cmdReady are both high; the response is a one-cycle rspValid
  // pulse with no back-pressure, and rspData/rspError hold until the next one.
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CW-1:0]            cmdChannel,
  input  logic [LW-1:0]            cmdLength,
  input  logic [MAX_WIDTH-1:0]     cmdData,
  output logic                     rspValid,
  output logic                     rspError,
  output logic [MAX_WIDTH-1:0]     rspData,
  output logic [CHANNEL_COUNT-1:0] spiClk,
  output logic [CHANNEL_COUNT-1:0] spiSdi,
  output logic [CHANNEL_COUNT-1:0] spiSel,
  input  logic [CHANNEL_COUNT-1:0] spiSdo,
  output logic [2:0]               dbgState
);

  spi_state_e state_q, state_d;
  logic [CW-1:0]            ch_q, ch_d;
  logic [LW-1:0]            len_q, len_d;
  logic                     le_q, le_d;
  logic [MAX_WIDTH-1:0]     tx_q, tx_d;
  logic [EW-1:0]            edge_q, edge_d;
  logic                     sclk_q, sclk_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_error_q, rsp_error_d;
  logic [MAX_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [CHANNEL_COUNT-1:0] spi_clk_q, spi_clk_d;
  logic [CHANNEL_COUNT-1:0] spi_sdi_q, spi_sdi_d;
  logic [CHANNEL_COUNT-1:0] spi_sel_q, spi_sel_d;

  logic                 tick;
  logic                 tick_load;
  logic                 sample_en;
  logic                 cap_clear;
  logic                 cmd_illegal;
  logic                 sel_phase;
  logic [MAX_WIDTH-1:0] cap_data;

  assign cmd_illegal = (cmdLength == '0)
                    || (32'(cmdLength) > 32'(MAX_WIDTH))
                    || (32'(cmdChannel) >= 32'(CHANNEL_COUNT));

  spi_half_tick #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_half_tick (
    .clk       (sysClk),
    .rst       (sysReset),
    .load      (tick_load),
    .load_value(divisor),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    len_d       = len_q;
    le_d        = le_q;
    tx_d        = tx_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    tick_load   = 1'b0;
    sample_en   = 1'b0;
    cap_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          if (cmd_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d   = SETUP;
            ch_d      = cmdChannel;
            len_d     = cmdLength;
            le_d      = LE_MASK[cmdChannel];
            // Left-align so the first bit to send sits in the MSB.
            tx_d      = cmdData << (LW'(MAX_WIDTH) - cmdLength);
            edge_d    = '0;
            sclk_d    = 1'b0;
            tick_load = 1'b1;
            cap_clear = 1'b1;
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          edge_d  = EW'(1);
        end
      end
      SHIFT: begin
        if (tick) begin
          if (edge_q == {len_q, 1'b0}) begin
            state_d = HOLD;
          end else if (sclk_q) begin
            // End of the high half: take the synchronised rising-edge sample.
            sclk_d    = 1'b0;
            tx_d      = tx_q << 1;
            sample_en = 1'b1;
            edge_d    = edge_q + EW'(1);
          end else begin
            sclk_d = 1'b1;
            edge_d = edge_q + EW'(1);
          end
        end
      end
      HOLD: begin
        if (tick) state_d = le_q ? LATCH : GAP;
      end
      LATCH: begin
        if (tick) state_d = GAP;
      end
      GAP: begin
        if (tick) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_data_d  = cap_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pins are computed from next-state values so every pin is a flop output.
  always_comb begin
    sel_phase = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
    spi_clk_d = '0;
    spi_sdi_d = '0;
    spi_sel_d = ~LE_MASK;
    for (int n = 0; n < CHANNEL_COUNT; n++) begin
      if (ch_d == CW'(n)) begin
        spi_clk_d[n] = sclk_d && (state_d == SHIFT);
        spi_sdi_d[n] = sel_phase && tx_d[MAX_WIDTH-1];
        if (LE_MASK[n] ? (state_d == LATCH) : sel_phase) spi_sel_d[n] = LE_MASK[n];
      end
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      len_q       <= '0;
      le_q        <= 1'b0;
      tx_q        <= '0;
      edge_q      <= '0;
      sclk_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      spi_clk_q   <= '0;
      spi_sdi_q   <= '0;
      spi_sel_q   <= ~LE_MASK;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      len_q       <= len_d;
      le_q        <= le_d;
      tx_q        <= tx_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      spi_clk_q   <= spi_clk_d;
      spi_sdi_q   <= spi_sdi_d;
      spi_sel_q   <= spi_sel_d;
    end
  end

`ifdef MULTI_SPI_READBACK_EN
  logic [CHANNEL_COUNT-1:0] sdo_meta_q;
  logic [CHANNEL_COUNT-1:0] sdo_sync_q;
  logic [MAX_WIDTH-1:0]     cap_q, cap_d;

  always_comb begin
    cap_d = cap_q;
    if (cap_clear) begin
      cap_d = '0;
    end else if (sample_en) begin
      cap_d = {cap_q[MAX_WIDTH-2:0], sdo_sync_q[ch_q]};
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      sdo_meta_q <= '0;
      sdo_sync_q <= '0;
      cap_q      <= '0;
    end else begin
      sdo_meta_q <= spiSdo;
      sdo_sync_q <= sdo_meta_q;
      cap_q      <= cap_d;
    end
  end

  assign cap_data = cap_q;
`else
  logic unused_readback;
  assign unused_readback = ^{spiSdo, sample_en, cap_clear};
  assign cap_data        = '0;
`endif

  assign cmdReady = (state_q == IDLE);
  assign rspValid = rsp_valid_q;
  assign rspError = rsp_error_q;
  assign rspData  = rsp_data_q;
  assign spiClk   = spi_clk_q;
  assign spiSdi   = spi_sdi_q;
  assign spiSel   = spi_sel_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_multi_spi_master.sv
// Directed bench for multi_spi_master: three channels, channel 1 latch-enable style.
module tb_multi_spi_master;

  localparam int             NCH      = 3;
  localparam int             MW       = 32;
  localparam int             DW       = 8;
  localparam logic [NCH-1:0] IDLE_SEL = 3'b101;

  logic           sysClk = 1'b0;
  logic           sysReset;
  logic [DW-1:0]  divisor;
  logic           cmdValid;
  logic           cmdReady;
  logic [1:0]     cmdChannel;
  logic [5:0]     cmdLength;
  logic [MW-1:0]  cmdData;
  logic           rspValid;
  logic           rspError;
  logic [MW-1:0]  rspData;
  logic [NCH-1:0] spiClk;
  logic [NCH-1:0] spiSdi;
  logic [NCH-1:0] spiSel;
  logic [NCH-1:0] spiSdo;
  logic [2:0]     dbgState;

  logic           sdo_loop;
  logic [NCH-1:0] sdo_force;
  assign spiSdo = sdo_loop ? spiSdi : sdo_force;

  multi_spi_master #(
    .CHANNEL_COUNT(NCH),
    .MAX_WIDTH    (MW),
    .DIVISOR_WIDTH(DW),
    .LE_MASK      (3'b010)
  ) dut (
    .sysClk    (sysClk),
    .sysReset  (sysReset),
    .divisor   (divisor),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .cmdChannel(cmdChannel),
    .cmdLength (cmdLength),
    .cmdData   (cmdData),
    .rspValid  (rspValid),
    .rspError  (rspError),
    .rspData   (rspData),
    .spiClk    (spiClk),
    .spiSdi    (spiSdi),
    .spiSel    (spiSel),
    .spiSdo    (spiSdo),
    .dbgState  (dbgState)
  );

  // Clock and watchdog
  always #5 sysClk = ~sysClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [MW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Pin monitor
  int          mon_ch;
  int          rise_cnt, sel_act, sel_clk, other_bad, hi_run, hi_min, hi_max;
  logic [31:0] sdi_bits;
  logic        prev_clk;

  always @(negedge sysClk) begin
    for (int n = 0; n < NCH; n++) begin
      if (n != mon_ch && (spiClk[n] || spiSdi[n] || spiSel[n] != IDLE_SEL[n])) other_bad++;
    end
    if (mon_ch < NCH) begin
      if (spiClk[mon_ch] && !prev_clk) begin
        rise_cnt++;
        sdi_bits = {sdi_bits[30:0], spiSdi[mon_ch]};
      end
      if (spiClk[mon_ch]) begin
        hi_run++;
      end else if (hi_run > 0) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      prev_clk = spiClk[mon_ch];
      if (spiSel[mon_ch] != IDLE_SEL[mon_ch]) begin
        sel_act++;
        if (spiClk[mon_ch]) sel_clk++;
      end
    end
  end

  function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef MULTI_SPI_READBACK_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon(input int ch);
    mon_ch    = ch;
    rise_cnt  = 0;
    sel_act   = 0;
    sel_clk   = 0;
    other_bad = 0;
    hi_run    = 0;
    hi_min    = 1000;
    hi_max    = 0;
    sdi_bits  = '0;
    prev_clk  = 1'b0;
  endtask

  // Drive a command (called just after a falling edge) and return after the accept edge.
  task automatic issue(input int ch, input int len, input logic [31:0] data, input int div,
                       input logic [31:0] exp);
    int w;
    w          = 0;
    cmdChannel = 2'(ch);
    cmdLength  = 6'(len);
    cmdData    = data;
    divisor    = 8'(div);
    cmdValid   = 1'b1;
    exp_q.push_back(exp);
    while (!cmdReady && w < 200) begin
      @(negedge sysClk);
      w++;
    end
    check("accept_wait", 32'(w < 200), 1);
    @(posedge sysClk);
  endtask

  // Count clock edges from accept until rspValid is sampled high.
  task automatic wait_rsp(input int bound, input int new_div, output int lat);
    lat = 0;
    do begin
      @(negedge sysClk);
      lat++;
      if (lat == 1) begin
        cmdValid = 1'b0;
        divisor  = 8'(new_div);
      end
    end while (!rspValid && lat < bound);
  endtask

  task automatic check_rsp(input string tag, input logic err_exp);
    logic [31:0] e;
    e = 32'hDEAD_BEEF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(rspValid), 1);
    check({tag, "_data"}, rspData, e);
    check({tag, "_err"}, 32'(rspError), 32'(err_exp));
  endtask

  int lat, cnt, seen;
  int ill_ch[3]  = '{0, 0, 3};
  int ill_len[3] = '{0, 33, 8};

  initial begin
    sysReset   = 1'b1;
    cmdValid   = 1'b0;
    cmdChannel = '0;
    cmdLength  = '0;
    cmdData    = '0;
    divisor    = '0;
    sdo_loop   = 1'b1;
    sdo_force  = '0;
    clr_mon(99);
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    sysReset = 1'b0;
    @(negedge sysClk);

    // Reset state
    check("rst_ready", 32'(cmdReady), 1);
    check("rst_valid", 32'(rspValid), 0);
    check("rst_error", 32'(rspError), 0);
    check("rst_data", rspData, 0);
    check("rst_clk", 32'(spiClk), 0);
    check("rst_sdi", 32'(spiSdi), 0);
    check("rst_sel", 32'(spiSel), 32'b101);
    check("rst_state", 32'(dbgState), 0);

    // CS channel 0, 8 bits, divisor 1, SDO looped back
    @(negedge sysClk);
    clr_mon(0);
    issue(0, 8, 32'hA5, 1, rb(32'hA5));
    wait_rsp(200, 1, lat);
    check("t1_latency", lat, 39);
    check_rsp("t1", 1'b0);
    check("t1_rises", rise_cnt, 8);
    check("t1_sdi_seq", sdi_bits[7:0], 32'hA5);
    check("t1_sel_cycles", sel_act, 36);
    check("t1_others_idle", other_bad, 0);

    // LE channel 1, 24 bits, divisor 0, SDO held high
    @(negedge sysClk);
    clr_mon(1);
    sdo_loop  = 1'b0;
    sdo_force = 3'b111;
    issue(1, 24, 32'h123456, 0, rb(32'h00FF_FFFF));
    wait_rsp(200, 0, lat);
    check("t2_latency", lat, 53);
    check_rsp("t2", 1'b0);
    check("t2_rises", rise_cnt, 24);
    check("t2_sdi_seq", sdi_bits[23:0], 32'h123456);
    check("t2_le_cycles", sel_act, 1);
    check("t2_le_during_clk", sel_clk, 0);
    check("t2_others_idle", other_bad, 0);

    // Illegal commands: zero length, over-length, out-of-range channel
    for (int i = 0; i < 3; i++) begin
      @(negedge sysClk);
      clr_mon(99);
      issue(ill_ch[i], ill_len[i], 32'hFFFF_FFFF, 0, 32'h0);
      wait_rsp(10, 0, lat);
      check("t3_latency", lat, 1);
      check_rsp("t3", 1'b1);
      check("t3_ready", 32'(cmdReady), 1);
      @(negedge sysClk);
      check("t3_pulse", 32'(rspValid), 0);
      check("t3_pins_idle", other_bad, 0);
    end

    // Back-to-back: second command held valid during the first
    @(negedge sysClk);
    clr_mon(0);
    sdo_force = 3'b111;
    issue(0, 4, 32'h9, 0, rb(32'hF));
    @(negedge sysClk);
    cmdChannel = 2'd2;
    cmdLength  = 6'd3;
    cmdData    = 32'h5;
    exp_q.push_back(rb(32'h7));
    cnt = 1;
    while (!cmdReady && cnt < 100) begin
      @(negedge sysClk);
      cnt++;
    end
    check("t4_accept_gap", cnt, 12);
    check_rsp("t4a", 1'b0);
    @(posedge sysClk);
    wait_rsp(100, 0, lat);
    check("t4b_latency", lat, 10);
    check_rsp("t4b", 1'b0);

    // Reset during bit 5 of a 16-bit transfer
    @(negedge sysClk);
    clr_mon(0);
    sdo_loop = 1'b1;
    issue(0, 16, 32'hBEEF, 1, 32'h0);
    @(negedge sysClk);
    cmdValid = 1'b0;
    cnt = 0;
    while (rise_cnt < 5 && cnt < 200) begin
      @(negedge sysClk);
      cnt++;
    end
    check("t5_reached_bit5", rise_cnt, 5);
    sysReset = 1'b1;
    #1;
    check("t5_clk", 32'(spiClk), 0);
    check("t5_sdi", 32'(spiSdi), 0);
    check("t5_sel", 32'(spiSel), 32'b101);
    check("t5_ready", 32'(cmdReady), 1);
    check("t5_valid", 32'(rspValid), 0);
    check("t5_state", 32'(dbgState), 0);
    void'(exp_q.pop_back());
    @(negedge sysClk);
    @(negedge sysClk);
    sysReset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge sysClk);
      if (rspValid) seen++;
    end
    check("t5_no_response", seen, 0);
    clr_mon(2);
    issue(2, 16, 32'hBEEF, 1, rb(32'hBEEF));
    wait_rsp(300, 1, lat);
    check("t5b_latency", lat, 71);
    check_rsp("t5b", 1'b0);
    check("t5b_rises", rise_cnt, 16);
    check("t5b_sdi_seq", sdi_bits[15:0], 32'hBEEF);

    // Divisor changed from 3 to 0 right after accept
    @(negedge sysClk);
    clr_mon(0);
    issue(0, 4, 32'hC, 3, rb(32'hC));
    wait_rsp(300, 0, lat);
    check("t6_latency", lat, 45);
    check_rsp("t6", 1'b0);
    check("t6_rises", rise_cnt, 4);
    check("t6_high_min", hi_min, 4);
    check("t6_high_max", hi_max, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_spi_master.md
# multi_spi_master

Parametrised SPI master serving `CHANNEL_COUNT` independent serial buses (AFE attenuator chains, AMI bias/monitor devices) from one command port in the system clock domain. It is the successor to the fixed two-bus AFE/AMI shifters. It adds:
- per-channel select style (active-low chip select or post-shift latch-enable pulse),
- runtime clock divisor,
- variable word length up to `MAX_WIDTH`,
- optional MISO readback.

It sits between the CSR/software register block and the board SPI pins.

## Interface
- `CHANNEL_COUNT`, 2, number of SPI buses.
- `MAX_WIDTH`, 32, longest word in bits.
- `DIVISOR_WIDTH`, 8, width of runtime divisor.
- `LE_MASK`, 0, bit *n* = 1 makes channel *n* latch-enable style; 0 makes it chip-select style.
- `sysClk` in 1: sole clock.
- `sysReset` in 1: asynchronous, active-high reset.
- `divisor` in DIVISOR_WIDTH: half SCLK period = `divisor`+1 sysClk cycles.
- `cmdValid` in 1; `cmdReady` out 1: command handshake.
- `cmdChannel` in clog2(CHANNEL_COUNT): target bus.
- `cmdLength` in clog2(MAX_WIDTH+1): bits to shift.
- `cmdData` in MAX_WIDTH: bit `cmdLength`-1 is sent first.
- `rspValid` out 1; `rspError` out 1; `rspData` out MAX_WIDTH: completion result.
- `spiClk`, `spiSdi`, `spiSel` out CHANNEL_COUNT; `spiSdo` in CHANNEL_COUNT: bus pins.

## Operation
- **Command acceptance.** A command is accepted on `cmdValid && cmdReady`. `cmdReady` = (state == IDLE). `divisor`, channel, length and data are captured at accept and are immune to later changes.
- **Error commands.** An illegal command (`cmdLength` == 0, `cmdLength` > `MAX_WIDTH`, or `cmdChannel` ≥ `CHANNEL_COUNT`) is still accepted but produces no pin activity. Next cycle: `rspValid`=1, `rspError`=1, `rspData`=0.
- **State machine**, one tick per half period H = `divisor`+1:
  - IDLE → SETUP (select active, first SDI bit driven, 1 H)
  - SETUP → SHIFT (2·L half periods; SCLK rises on odd half, falls on even; SDI advances after each fall)
  - SHIFT → HOLD (1 H)
  - HOLD → LATCH (1 H, LE channels only)
  - LATCH → GAP (select idle, 1 H)
  - GAP → IDLE
- **Mode 0 framing.** SCLK idles low, SDO is sampled on the rising edge, MSB first.
- **Select polarity.**
  - CS channel: `spiSel` idles 1 and is 0 from SETUP through HOLD.
  - LE channel: `spiSel` idles 0 and is 1 only during LATCH.
- **Unselected channels** keep clk/sdi low and their select at idle level throughout.
- **Completion.** In the first IDLE cycle after GAP: `rspValid` pulses 1 cycle with `rspError`=0. `rspData` holds the last L sampled bits right-aligned, zero-extended, and is held until the next response.
- **Back-to-back commands.** A new command may be accepted in the same cycle as `rspValid`.

## Timing
- Reset values:
  - `spiClk`=0, `spiSdi`=0.
  - `spiSel[n]` = 1 for CS channels, 0 for LE channels.
  - `rspValid`=0, `rspError`=0, `rspData`=0.
  - `cmdReady`=1, state IDLE.
- Transaction latency from accept to `rspValid` (L = `cmdLength`):
  - CS channel: (2L+3)·H + 1 cycles.
  - LE channel: (2L+4)·H + 1 cycles.
- Error command latency from accept to `rspValid`: 1 cycle.
- All pin outputs are registered, with no combinational path from inputs.
- `divisor`=0 gives SCLK = sysClk/2.
- Maximum L=`MAX_WIDTH`: shift and bit counters must not wrap.
- Reset asserted mid-transaction forces every output to its reset value immediately (asynchronous). No response is produced for the aborted command.

## Configuration
- `MULTI_SPI_READBACK_EN` defined: the SDO synchronisers (2 flops per channel) and the capture shift register are built. `rspData` carries the sampled bits.
- Macro undefined: there is no capture logic, `spiSdo` is ignored, and `rspData` is constant 0. Handshake and timing are unchanged.

## Structure
- Package `multi_spi_pkg`:
  - state encoding (IDLE, SETUP, SHIFT, HOLD, LATCH, GAP)
  - length/channel width functions
- Sub-module `spi_half_tick`: loadable down-counter producing a one-cycle tick every `divisor`+1 cycles. It is restarted at accept.

## Test plan
1. CS channel 0, L=8, data 0xA5, `divisor`=1, SDO looped to SDI:
   - SDI sequence 1,0,1,0,0,1,0,1
   - 8 SCLK rises
   - `rspData`=0xA5, `rspValid` at cycle 39 after accept.
2. `LE_MASK`=2'b10, channel 1, L=24, data 0x123456, `divisor`=0:
   - `spiSel[1]` stays low during shift, then goes high for exactly 1 cycle after HOLD.
   - `rspValid` at cycle 53.
3. Illegal commands L=0, L=33, and channel=2:
   - each gives `rspError`=1 on the next cycle
   - all pins stay idle.
4. Back-to-back: second command held valid is accepted in the same cycle as the first `rspValid`, with no idle gap beyond GAP.
5. Assert `sysReset` at SHIFT bit 5 of a 16-bit transfer:
   - all outputs return to reset values immediately
   - no `rspValid` is produced
   - next command runs normally.
6. `divisor` changed from 3 to 0 mid-transfer: SCLK half period stays 4 cycles until completion.
